// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and default threshold margins for the parametrised FIFO
package fifo_pkg;
  localparam int AF_MARGIN = 2;
  localparam int AE_MARGIN = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_W register array, synchronous write, asynchronous read
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  // storage is written on accepted writes only and is never reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with level flags, fill count, error pulses and optional FWFT
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - AF_MARGIN,
  parameter int AE_LEVEL = AE_MARGIN,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_AF    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] L_AE    = (AW+1)'(AE_LEVEL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if (AW != clog2(DEPTH)) begin : g_chk_aw
    $error("fifo_sync_param: AW is derived from DEPTH and must not be overridden");
  end
  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_chk_lvl
    $error("fifo_sync_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [AW:0]       r_wr_ptr, r_rd_ptr, r_count;
  logic [DATA_W-1:0] r_dout, w_rdata;
  logic              r_ovf, r_udf, w_wr_acc, w_rd_acc, w_unused_msb;

  assign full         = r_count == L_DEPTH;
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= L_AF;
  assign almost_empty = r_count <= L_AE;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign w_rd_acc     = rd_en & ~empty;
  assign w_wr_acc     = wr_en & (~full | w_rd_acc);
  assign dout         = (FWFT != 0) ? (empty ? '0 : w_rdata) : r_dout;
  assign w_unused_msb = r_wr_ptr[AW] ^ r_rd_ptr[AW];

  fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (din),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // advance pointers and count on accepted transfers, flag rejected requests, register read data
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (AW+1)'(w_wr_acc);
      r_rd_ptr <= r_rd_ptr + (AW+1)'(w_rd_acc);
      r_count  <= r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
      r_ovf    <= wr_en & ~w_wr_acc;
      r_udf    <= rd_en & ~w_rd_acc;
      if (w_rd_acc) r_dout <= w_rdata;
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: three FIFO variants in lockstep against a queue-based reference model
module tb_fifo_sync_param;
  logic clk = 0, reset_n = 1, wr_en = 0, rd_en = 0;
  logic [7:0] din = 0;
  logic [7:0] dout [3];
  logic [4:0] count [3];
  logic full [3], empty [3], af [3], ae [3], ovf [3], udf [3];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout[0]),
    .full(full[0]), .empty(empty[0]), .almost_full(af[0]), .almost_empty(ae[0]),
    .count(count[0]), .overflow(ovf[0]), .underflow(udf[0]));
  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout[1]),
    .full(full[1]), .empty(empty[1]), .almost_full(af[1]), .almost_empty(ae[1]),
    .count(count[1]), .overflow(ovf[1]), .underflow(udf[1]));
  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3), .FWFT(0)) u2 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout[2]),
    .full(full[2]), .empty(empty[2]), .almost_full(af[2]), .almost_empty(ae[2]),
    .count(count[2]), .overflow(ovf[2]), .underflow(udf[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // reference model: contents as a queue, registered read word and error pulses
  logic [7:0] q [$];
  logic [7:0] m_dout = 0;
  logic m_ovf = 0, m_udf = 0;
  always @(posedge clk or negedge reset_n) begin
    logic ra, wa;
    if (!reset_n) begin
      q.delete();
      m_dout = 0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      ra = rd_en && q.size() != 0;
      wa = wr_en && (q.size() < 16 || ra);
      m_ovf = wr_en && !wa;
      m_udf = rd_en && !ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
    end
  end

  // compare every output of every variant against the model each cycle
  always @(negedge clk) begin
    int n;
    n = q.size();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count%0d", i), count[i], n);
      chk($sformatf("full%0d", i), full[i], n == 16);
      chk($sformatf("empty%0d", i), empty[i], n == 0);
      chk($sformatf("af%0d", i), af[i], (i == 2) ? n >= 12 : n >= 14);
      chk($sformatf("ae%0d", i), ae[i], (i == 2) ? n <= 3 : n <= 2);
      chk($sformatf("ovf%0d", i), ovf[i], m_ovf);
      chk($sformatf("udf%0d", i), udf[i], m_udf);
      chk($sformatf("dout%0d", i), dout[i], (i == 1) ? ((n != 0) ? q[0] : 8'h00) : m_dout);
    end
  end

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count[0], 0);
    chk("rst_empty", empty[0], 1);
    chk("rst_full", full[0], 0);
    chk("rst_ae", ae[0], 1);
    chk("rst_af", af[0], 0);
    chk("rst_dout", dout[0], 0);
    @(negedge clk) reset_n = 1;

    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 8'(8'h10 + k));
      chk("t1_count", count[0], k);
      chk("t1_af", af[0], k >= 14);
      chk("t1_full", full[0], k == 16);
    end
    step(1, 0, 8'hEE);
    chk("t1_ovf", ovf[0], 1);
    chk("t1_ovf_count", count[0], 16);
    step(0, 0, 0);
    chk("t1_ovf_clr", ovf[0], 0);
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 0);
      chk("t1_rd", dout[0], 8'h11 + k);
    end

    step(0, 1, 0);
    chk("t2_udf", udf[0], 1);
    chk("t2_dout", dout[0], 8'h20);
    chk("t2_count", count[0], 0);
    step(1, 1, 8'h77);
    chk("t2_wr_rd_udf", udf[0], 1);
    chk("t2_wr_rd_count", count[0], 1);
    step(0, 0, 0);
    chk("t2_udf_clr", udf[0], 0);

    for (int k = 0; k < 15; k++) step(1, 0, 8'($urandom));
    chk("t3_full", full[0], 1);
    for (int k = 0; k < 40; k++) begin
      step(1, 1, 8'hAA);
      chk("t3_no_ovf", ovf[0], 0);
      chk("t3_still_full", full[0], 1);
    end
    chk("t3_dout", dout[0], 8'hAA);
    for (int k = 0; k < 16; k++) step(0, 1, 0);
    chk("t3_drained", empty[0], 1);

    step(1, 0, 8'h5A);
    chk("t4_fwft_dout", dout[1], 8'h5A);
    chk("t4_fwft_empty", empty[1], 0);
    step(0, 1, 0);
    chk("t4_pop_empty", empty[1], 1);
    chk("t4_pop_dout", dout[1], 0);

    for (int k = 0; k < 9; k++) step(1, 0, 8'($urandom));
    step(0, 0, 0);
    chk("t5_count9", count[0], 9);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("t5_count", count[0], 0);
    chk("t5_empty", empty[0], 1);
    chk("t5_dout0", dout[0], 0);
    chk("t5_dout1", dout[1], 0);
    @(negedge clk) reset_n = 1;
    step(1, 0, 8'h3C);
    chk("t5_fwft_after", dout[1], 8'h3C);
    step(0, 1, 0);
    chk("t5_readback", dout[0], 8'h3C);

    chk("t6_ae0", ae[2], 1);
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 8'(k));
      chk("t6_fill_ae", ae[2], k <= 3);
      chk("t6_fill_af", af[2], k >= 12);
    end
    for (int k = 15; k >= 0; k--) begin
      step(0, 1, 0);
      chk("t6_drain_ae", ae[2], k <= 3);
      chk("t6_drain_af", af[2], k >= 12);
    end

    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 70 : (ph == 1) ? 30 : (ph == 2) ? 50 : 90;
      pr = (ph == 0) ? 30 : (ph == 1) ? 70 : (ph == 2) ? 50 : 90;
      for (int k = 0; k < 400; k++)
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
    end
    step(0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
